// File: rtl/sram_tdm_arbiter_1rw_if.sv
// Signal bundle between two val/rdy memory clients, the TDM arbiter and a
// 1rw combinational SRAM. The slave side is the arbiter. The master side
// is everything around it: both clients plus the SRAM read-data return.
interface sram_tdm_arbiter_1rw_if #(
  parameter int p_data_nbits  = 32,
  parameter int p_num_entries = 256
);
  localparam int c_addr_nbits  = $clog2(p_num_entries);
  localparam int c_data_nbytes = (p_data_nbits + 7) / 8;

  logic                     req0_val;
  logic                     req0_rdy;
  logic                     req0_type;
  logic [c_addr_nbits-1:0]  req0_addr;
  logic [c_data_nbytes-1:0] req0_byte_en;
  logic [p_data_nbits-1:0]  req0_data;
  logic                     resp0_val;
  logic                     resp0_rdy;
  logic                     resp0_type;
  logic [p_data_nbits-1:0]  resp0_data;

  logic                     req1_val;
  logic                     req1_rdy;
  logic                     req1_type;
  logic [c_addr_nbits-1:0]  req1_addr;
  logic [c_data_nbytes-1:0] req1_byte_en;
  logic [p_data_nbits-1:0]  req1_data;
  logic                     resp1_val;
  logic                     resp1_rdy;
  logic                     resp1_type;
  logic [p_data_nbits-1:0]  resp1_data;

  logic                     sram_read_en;
  logic [c_addr_nbits-1:0]  sram_read_addr;
  logic [p_data_nbits-1:0]  sram_read_data;
  logic                     sram_write_en;
  logic [c_data_nbytes-1:0] sram_write_byte_en;
  logic [c_addr_nbits-1:0]  sram_write_addr;
  logic [p_data_nbits-1:0]  sram_write_data;
  logic                     sram_sd;

  modport slave (
    input  req0_val, req0_type, req0_addr, req0_byte_en, req0_data, resp0_rdy,
    input  req1_val, req1_type, req1_addr, req1_byte_en, req1_data, resp1_rdy,
    input  sram_read_data,
    output req0_rdy, resp0_val, resp0_type, resp0_data,
    output req1_rdy, resp1_val, resp1_type, resp1_data,
    output sram_read_en, sram_read_addr, sram_write_en, sram_write_byte_en,
    output sram_write_addr, sram_write_data, sram_sd
  );

  modport master (
    output req0_val, req0_type, req0_addr, req0_byte_en, req0_data, resp0_rdy,
    output req1_val, req1_type, req1_addr, req1_byte_en, req1_data, resp1_rdy,
    output sram_read_data,
    input  req0_rdy, resp0_val, resp0_type, resp0_data,
    input  req1_rdy, resp1_val, resp1_type, resp1_data,
    input  sram_read_en, sram_read_addr, sram_write_en, sram_write_byte_en,
    input  sram_write_addr, sram_write_data, sram_sd
  );
endinterface

// File: rtl/sram_tdm_arbiter_1rw.sv
// TDM arbiter for one 1rw combinational SRAM shared by two clients.
// Ownership rotates on a fixed cycle schedule, so a client's grant timing
// never depends on the other client's traffic. Each port gets a one-entry
// response register. The owner may only issue when its register is empty.
module sram_tdm_arbiter_1rw #(
  parameter int p_data_nbits  = 32,
  parameter int p_num_entries = 256,
  parameter int p_slot_cycles = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  sram_tdm_arbiter_1rw_if.slave bus
);
  localparam int c_addr_nbits  = $clog2(p_num_entries);
  localparam int c_data_nbytes = (p_data_nbits + 7) / 8;
  localparam int c_cnt_nbits   = $clog2(p_slot_cycles);
  localparam logic [c_cnt_nbits-1:0] c_cnt_last = c_cnt_nbits'(p_slot_cycles - 1);

  typedef enum logic { OWN_P0 = 1'b0, OWN_P1 = 1'b1 } owner_e;

  owner_e                   owner_q;
  logic [c_cnt_nbits-1:0]   slot_cnt_q;

  logic [1:0]               full_q, full_d;
  logic [1:0]               type_q, type_d;
  logic [p_data_nbits-1:0]  data_q [2];
  logic [p_data_nbits-1:0]  data_d [2];

  logic [1:0]               req_val, req_rdy, fire, resp_rdy;
  logic                     any_fire;
  logic                     sel_type;
  logic [c_addr_nbits-1:0]  sel_addr;
  logic [c_data_nbytes-1:0] sel_be;
  logic [p_data_nbits-1:0]  sel_data;

  assign req_val  = {bus.req1_val, bus.req0_val};
  assign resp_rdy = {bus.resp1_rdy, bus.resp0_rdy};

  // The access window is the first cycle of a slot. It goes only to the owner, and only if its response slot is free.
  assign req_rdy[0] = !reset && (slot_cnt_q == '0) && (owner_q == OWN_P0) && !full_q[0];
  assign req_rdy[1] = !reset && (slot_cnt_q == '0) && (owner_q == OWN_P1) && !full_q[1];
  assign fire       = req_val & req_rdy;
  assign any_fire   = |fire;

  // Steer the owner's request fields to the SRAM; only the owner can fire.
  always_comb begin
    if (owner_q == OWN_P1) begin
      sel_type = bus.req1_type;
      sel_addr = bus.req1_addr;
      sel_be   = bus.req1_byte_en;
      sel_data = bus.req1_data;
    end else begin
      sel_type = bus.req0_type;
      sel_addr = bus.req0_addr;
      sel_be   = bus.req0_byte_en;
      sel_data = bus.req0_data;
    end
  end

  assign bus.req0_rdy           = req_rdy[0];
  assign bus.req1_rdy           = req_rdy[1];
  assign bus.sram_read_en       = any_fire && !sel_type;
  assign bus.sram_write_en      = any_fire && sel_type;
  assign bus.sram_read_addr     = sel_addr;
  assign bus.sram_write_addr    = sel_addr;
  assign bus.sram_write_byte_en = sel_be;
  assign bus.sram_write_data    = sel_data;
  assign bus.sram_sd            = (owner_q == OWN_P1);

  assign bus.resp0_val  = full_q[0];
  assign bus.resp0_type = type_q[0];
  assign bus.resp0_data = data_q[0];
  assign bus.resp1_val  = full_q[1];
  assign bus.resp1_type = type_q[1];
  assign bus.resp1_data = data_q[1];

  // Fixed ownership schedule: count through the slot, hand over at its last cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= OWN_P0;
      slot_cnt_q <= '0;
    end else if (slot_cnt_q == c_cnt_last) begin
      slot_cnt_q <= '0;
      owner_q    <= (owner_q == OWN_P0) ? OWN_P1 : OWN_P0;
    end else begin
      slot_cnt_q <= slot_cnt_q + c_cnt_nbits'(1);
    end
  end

  // Response registers: drain on consume, capture on fire (never both for one port).
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      full_d[n] = full_q[n];
      type_d[n] = type_q[n];
      data_d[n] = data_q[n];
      if (full_q[n] && resp_rdy[n]) full_d[n] = 1'b0;
      if (fire[n]) begin
        full_d[n] = 1'b1;
        type_d[n] = sel_type;
        data_d[n] = sel_type ? '0 : bus.sram_read_data;
      end
    end
  end

  // Valid flags are control state and take reset; payload just follows.
  always_ff @(posedge clk) begin
    if (reset) full_q <= '0;
    else       full_q <= full_d;
  end

  // Response payload registers.
  always_ff @(posedge clk) begin
    type_q    <= type_d;
    data_q[0] <= data_d[0];
    data_q[1] <= data_d[1];
  end

  a_one_enable: assert property (@(posedge clk) disable iff (reset)
    !(bus.sram_read_en && bus.sram_write_en));
  a_grant_slot0: assert property (@(posedge clk) disable iff (reset)
    (req_rdy != 2'b00) |-> (slot_cnt_q == '0));
  a_inputs_known: assert property (@(posedge clk) disable iff (reset)
    !$isunknown({bus.req0_type, bus.req1_type, bus.req0_val, bus.req1_val,
                 bus.resp0_rdy, bus.resp1_rdy}));
endmodule

// File: tb/tb_sram_tdm_arbiter_1rw.sv
// Bench for sram_tdm_arbiter_1rw. Requests wait in per-port queues until
// they are granted. A cycle-count schedule model predicts each grant and
// pushes the expected response. An independent monitor pops and compares
// it when the DUT hands the response over.
module tb_sram_tdm_arbiter_1rw;
  localparam int D = 32;
  localparam int N = 256;
  localparam int S = 4;
  localparam int A = 8;
  localparam int B = 4;

  typedef struct packed {
    logic         typ;
    logic [A-1:0] addr;
    logic [B-1:0] be;
    logic [D-1:0] data;
  } req_t;

  typedef struct packed {
    logic         typ;
    logic [D-1:0] data;
  } rsp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_tdm_arbiter_1rw_if #(.p_data_nbits(D), .p_num_entries(N)) bus ();

  sram_tdm_arbiter_1rw #(.p_data_nbits(D), .p_num_entries(N), .p_slot_cycles(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic         tb_val  [2];
  logic         tb_type [2];
  logic [A-1:0] tb_addr [2];
  logic [B-1:0] tb_be   [2];
  logic [D-1:0] tb_data [2];
  logic         tb_rrdy [2];

  assign bus.req0_val     = tb_val[0];
  assign bus.req0_type    = tb_type[0];
  assign bus.req0_addr    = tb_addr[0];
  assign bus.req0_byte_en = tb_be[0];
  assign bus.req0_data    = tb_data[0];
  assign bus.resp0_rdy    = tb_rrdy[0];
  assign bus.req1_val     = tb_val[1];
  assign bus.req1_type    = tb_type[1];
  assign bus.req1_addr    = tb_addr[1];
  assign bus.req1_byte_en = tb_be[1];
  assign bus.req1_data    = tb_data[1];
  assign bus.resp1_rdy    = tb_rrdy[1];

  logic [1:0]   d_rdy, d_rval, d_rtype;
  logic [D-1:0] d_rdata [2];
  assign d_rdy      = {bus.req1_rdy, bus.req0_rdy};
  assign d_rval     = {bus.resp1_val, bus.resp0_val};
  assign d_rtype    = {bus.resp1_type, bus.resp0_type};
  assign d_rdata[0] = bus.resp0_data;
  assign d_rdata[1] = bus.resp1_data;

  // Combinational-read SRAM with byte-enabled writes
  bit [D-1:0] mem [N];
  assign bus.sram_read_data = mem[bus.sram_read_addr];
  always @(posedge clk) begin
    if (bus.sram_write_en === 1'b1)
      for (int b = 0; b < B; b++)
        if (bus.sram_write_byte_en[b])
          mem[bus.sram_write_addr][8*b +: 8] <= bus.sram_write_data[8*b +: 8];
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [D-1:0] ref_mem [N];
  bit         mfull [2];
  int         cyc;
  int         rst_cnt;
  int         rmode [2];   // 0: hold resp_rdy low, 1: high, 2: random
  bit         rst_next;
  req_t       reqq0 [$];
  req_t       reqq1 [$];
  rsp_t       expq0 [$];
  rsp_t       expq1 [$];
  logic [D-1:0] last_data [2];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic req_t mk(logic typ, logic [A-1:0] addr, logic [B-1:0] be, logic [D-1:0] data);
    req_t r;
    r.typ = typ; r.addr = addr; r.be = be; r.data = data;
    return r;
  endfunction

  function automatic int qsz(int n);
    return (n == 0) ? reqq0.size() : reqq1.size();
  endfunction

  function automatic req_t head(int n);
    return (n == 0) ? reqq0[0] : reqq1[0];
  endfunction

  task automatic push_req(int n, req_t r);
    if (n == 0) reqq0.push_back(r); else reqq1.push_back(r);
  endtask

  task automatic push_rand(int n);
    push_req(n, mk(1'($urandom_range(0, 1)), A'($urandom_range(0, 7)), B'($urandom), $urandom));
  endtask

  // One clock: drive inputs at negedge, then check and advance the model.
  task automatic step();
    req_t r;
    req_t fr;
    rsp_t e;
    int   own;
    bit   win, er, any, nf;
    bit   fire [2];
    @(negedge clk);
    reset = rst_next;
    for (int n = 0; n < 2; n++) begin
      if (qsz(n) > 0) begin
        r = head(n);
        tb_val[n] = 1'b1; tb_type[n] = r.typ; tb_addr[n] = r.addr;
        tb_be[n] = r.be; tb_data[n] = r.data;
      end else begin
        tb_val[n] = 1'b0; tb_type[n] = 1'($urandom_range(0, 1));
        tb_addr[n] = A'($urandom); tb_be[n] = B'($urandom); tb_data[n] = $urandom;
      end
      if (rst_next)          tb_rrdy[n] = 1'b0;
      else if (rmode[n] == 2) tb_rrdy[n] = 1'($urandom_range(0, 1));
      else                    tb_rrdy[n] = (rmode[n] == 1);
    end
    #1;
    if (reset) begin
      chk("rst_rdy0", d_rdy[0], 0);
      chk("rst_rdy1", d_rdy[1], 0);
      chk("rst_read_en", bus.sram_read_en, 0);
      chk("rst_write_en", bus.sram_write_en, 0);
      if (rst_cnt > 0) begin
        chk("rst_resp_val0", d_rval[0], 0);
        chk("rst_resp_val1", d_rval[1], 0);
      end
      rst_cnt++;
      mfull[0] = 1'b0; mfull[1] = 1'b0;
      expq0.delete(); expq1.delete();
      cyc = 0;
    end else begin
      rst_cnt = 0;
      own = (cyc / S) % 2;
      win = (cyc % S) == 0;
      any = 1'b0;
      fr  = '0;
      for (int n = 0; n < 2; n++) begin
        er = win && (own == n) && !mfull[n];
        chk($sformatf("rdy%0d_cyc%0d", n, cyc), d_rdy[n], er);
        chk($sformatf("resp_val%0d_cyc%0d", n, cyc), d_rval[n], mfull[n]);
        fire[n] = er && tb_val[n];
        if (fire[n]) begin any = 1'b1; fr = head(n); end
      end
      chk("sram_sd", bus.sram_sd, own);
      chk("read_en", bus.sram_read_en, any && !fr.typ);
      chk("write_en", bus.sram_write_en, any && fr.typ);
      if (any && !fr.typ) chk("read_addr", bus.sram_read_addr, fr.addr);
      if (any && fr.typ) begin
        chk("write_addr", bus.sram_write_addr, fr.addr);
        chk("write_be", bus.sram_write_byte_en, fr.be);
        chk("write_data", bus.sram_write_data, fr.data);
      end
      for (int n = 0; n < 2; n++) begin
        nf = mfull[n];
        if (mfull[n] && tb_rrdy[n]) nf = 1'b0;
        if (fire[n]) begin
          e.typ  = fr.typ;
          e.data = fr.typ ? '0 : ref_mem[fr.addr];
          if (fr.typ)
            for (int b = 0; b < B; b++)
              if (fr.be[b]) ref_mem[fr.addr][8*b +: 8] = fr.data[8*b +: 8];
          if (n == 0) begin expq0.push_back(e); void'(reqq0.pop_front()); end
          else        begin expq1.push_back(e); void'(reqq1.pop_front()); end
          nf = 1'b1;
        end
        mfull[n] = nf;
      end
      cyc++;
    end
  endtask

  // Response monitor: compares each consumed response with the scoreboard head
  initial begin : monitor
    rsp_t e;
    bit   empty;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        for (int n = 0; n < 2; n++) begin
          if (d_rval[n] === 1'b1 && tb_rrdy[n] === 1'b1) begin
            empty = (n == 0) ? (expq0.size() == 0) : (expq1.size() == 0);
            if (empty) begin
              checks++; errors++;
              $display("FAIL resp%0d_unexpected: got data %0h expected no response", n, d_rdata[n]);
            end else begin
              if (n == 0) e = expq0.pop_front(); else e = expq1.pop_front();
              chk($sformatf("resp%0d_type", n), d_rtype[n], e.typ);
              chk($sformatf("resp%0d_data", n), d_rdata[n], e.data);
              last_data[n] = d_rdata[n];
            end
          end
        end
      end
    end
  end

  initial begin
    int i;
    for (int n = 0; n < 2; n++) begin
      tb_val[n] = 1'b0; tb_type[n] = 1'b0; tb_addr[n] = '0;
      tb_be[n] = '0; tb_data[n] = '0; tb_rrdy[n] = 1'b0;
      rmode[n] = 1; mfull[n] = 1'b0; last_data[n] = '0;
    end
    cyc = 0; rst_cnt = 0; rst_next = 1'b1;
    repeat (3) step();
    rst_next = 1'b0;

    // Idle schedule
    repeat (16) step();

    // Port 0 full write then read back
    push_req(0, mk(1'b1, 8'd5, 4'hF, 32'hDEADBEEF));
    push_req(0, mk(1'b0, 8'd5, 4'h0, 32'h0));
    repeat (24) step();
    chk("t2_read_data", last_data[0], 32'hDEADBEEF);

    // Port 1 partial write then read back
    push_req(1, mk(1'b1, 8'd5, 4'b0011, 32'h12345678));
    push_req(1, mk(1'b0, 8'd5, 4'h0, 32'h0));
    repeat (24) step();
    chk("t3_read_data", last_data[1], 32'hDEAD5678);

    // Both ports continuously valid
    for (int k = 0; k < 6; k++) begin push_rand(0); push_rand(1); end
    repeat (52) step();

    // Port 0 stalls its response; later windows must be skipped
    rmode[0] = 0;
    push_req(0, mk(1'b0, 8'd5, 4'h0, 32'h0));
    push_req(0, mk(1'b1, 8'd6, 4'hF, 32'hCAFEF00D));
    repeat (32) step();
    rmode[0] = 1;
    repeat (24) step();

    // Reset while port 1 holds a pending response
    rmode[1] = 0;
    push_req(1, mk(1'b0, 8'd5, 4'h0, 32'h0));
    i = 0;
    while (i < 20 && !mfull[1]) begin step(); i++; end
    chk("t6_grant_seen", mfull[1], 1);
    step();
    chk("t6_resp1_pending", d_rval[1], 1);
    rst_next = 1'b1;
    step();
    step();
    rst_next = 1'b0;
    rmode[1] = 1;
    step();
    chk("t6_resp1_val_after_reset", d_rval[1], 0);
    chk("t6_owner_after_reset", bus.sram_sd, 0);

    // Randomized traffic
    rmode[0] = 2; rmode[1] = 2;
    repeat (600) begin
      for (int n = 0; n < 2; n++)
        if (qsz(n) < 4 && $urandom_range(0, 3) == 0) push_rand(n);
      step();
    end

    // Drain
    rmode[0] = 1; rmode[1] = 1;
    i = 0;
    while (i < 200 && (qsz(0) > 0 || qsz(1) > 0 || mfull[0] || mfull[1] ||
                       expq0.size() > 0 || expq1.size() > 0)) begin
      step(); i++;
    end
    repeat (3) step();
    chk("drain_exp0", expq0.size(), 0);
    chk("drain_exp1", expq1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
